// File: rtl/test7_v2_ecc.sv
// SECDED (72,64) Hamming-protected RAM with write-time error injection and 1-cycle read.
// Optional ECC_ERR_CNT_EN adds saturating single/double error counters (sgl_cnt, dbl_cnt).
module test7_v2_ecc #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       INn,
    input  logic [63:0]       selectt,
    input  logic              W_EN,
    input  logic [ADDR_W-1:0] W_ADDR,
    input  logic              R_EN,
    input  logic [ADDR_W-1:0] R_ADDR,
    output logic [ADDR_W-1:0] R_ADDRr,
    output logic [63:0]       real_data,
    output logic [63:0]       wrong_real_data,
    output logic              SGLl,
    output logic              DBLl
`ifdef ECC_ERR_CNT_EN
    ,
    output logic [15:0]       sgl_cnt,
    output logic [15:0]       dbl_cnt
`endif
);

    // Codeword position (1..71) holding data bit k: the k-th non-power-of-two position.
    function automatic int data_pos(input int k);
        int n;
        int p;
        n = 0;
        p = 0;
        for (int q = 1; q < 72; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (n == k) p = q;
                n++;
            end
        end
        return p;
    endfunction

    // Positions 1..71 whose index has bit i set.
    function automatic logic [71:0] pos_mask(input int i);
        logic [71:0] m;
        m = '0;
        for (int q = 1; q < 72; q++) begin
            m[q] = ((q >> i) & 1) != 0;
        end
        return m;
    endfunction

    // Stored word layout: [71] overall parity, [70:64] P6..P0, [63:0] data (after injection).
    logic [71:0] mem [DEPTH];
    logic [71:0] rd_word_reg;
    logic [71:0] enc_cw;
    logic [71:0] dec_cw;
    logic [7:0]  enc_chk;
    logic [6:0]  syndrome;
    logic        par_err;

    assign enc_cw[0] = 1'b0;
    assign dec_cw[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_data
            localparam int DPOS = data_pos(gi);
            assign enc_cw[DPOS]  = INn[gi];
            assign dec_cw[DPOS]  = rd_word_reg[gi];
            assign real_data[gi] = rd_word_reg[gi] ^ (par_err && (syndrome == 7'(DPOS)));
        end

        for (genvar gi = 0; gi < 7; gi++) begin : g_check
            localparam logic [71:0] MASK = pos_mask(gi);
            assign enc_cw[2**gi] = 1'b0;
            assign dec_cw[2**gi] = rd_word_reg[64+gi];
            assign enc_chk[gi]   = ^(enc_cw & MASK);
            assign syndrome[gi]  = ^(dec_cw & MASK);
        end
    endgenerate

    // Overall parity covers data and the seven Hamming check bits.
    assign enc_chk[7] = (^enc_cw) ^ (^enc_chk[6:0]);
    assign par_err    = (^dec_cw) ^ rd_word_reg[71];

    assign wrong_real_data = rd_word_reg[63:0];
    assign SGLl = par_err && (syndrome <= 7'd71);
    assign DBLl = (!par_err && (syndrome != 7'd0)) || (par_err && (syndrome > 7'd71));

    // Write port has no reset so a write coinciding with reset still lands.
    always_ff @(posedge clk) begin
        if (W_EN && (int'(W_ADDR) < DEPTH)) begin
            mem[W_ADDR] <= {enc_chk, INn ^ selectt};
        end
    end

    // Nonblocking read of mem gives read-first behaviour on a same-address write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_word_reg <= '0;
            R_ADDRr     <= '0;
        end else if (R_EN) begin
            rd_word_reg <= mem[R_ADDR];
            R_ADDRr     <= R_ADDR;
        end
    end

`ifdef ECC_ERR_CNT_EN
    logic rd_done_reg;

    // Counts once per read, on the edge after the read word was captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_done_reg <= 1'b0;
            sgl_cnt     <= '0;
            dbl_cnt     <= '0;
        end else begin
            rd_done_reg <= R_EN;
            if (rd_done_reg && SGLl && (sgl_cnt != 16'hFFFF)) sgl_cnt <= sgl_cnt + 16'd1;
            if (rd_done_reg && DBLl && (dbl_cnt != 16'hFFFF)) dbl_cnt <= dbl_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_test7_v2_ecc.sv
// Self-checking bench for test7_v2_ecc: directed plan plus randomized SECDED traffic vs a behavioural model.
module tb_test7_v2_ecc;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              reset;
    logic [63:0]       INn, selectt;
    logic              W_EN, R_EN;
    logic [ADDR_W-1:0] W_ADDR, R_ADDR, R_ADDRr;
    logic [63:0]       real_data, wrong_real_data;
    logic              SGLl, DBLl;
`ifdef ECC_ERR_CNT_EN
    logic [15:0]       sgl_cnt, dbl_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model: clean data and injection mask per written address.
    logic [63:0] md [int];
    logic [63:0] ms [int];
    logic [63:0] er, ew;
    logic        es, ed;
    logic [143:0] got, want;

    always #5 clk = ~clk;

    test7_v2_ecc #(.ADDR_W(ADDR_W), .DEPTH(16384)) dut (
        .clk(clk), .reset(reset), .INn(INn), .selectt(selectt),
        .W_EN(W_EN), .W_ADDR(W_ADDR), .R_EN(R_EN), .R_ADDR(R_ADDR),
        .R_ADDRr(R_ADDRr), .real_data(real_data), .wrong_real_data(wrong_real_data),
        .SGLl(SGLl), .DBLl(DBLl)
`ifdef ECC_ERR_CNT_EN
        , .sgl_cnt(sgl_cnt), .dbl_cnt(dbl_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic [63:0] d, input logic [63:0] s);
        W_EN = 1'b1; W_ADDR = ADDR_W'(a); INn = d; selectt = s;
        tick();
        W_EN = 1'b0;
        md[a] = d;
        ms[a] = s;
        $display("write addr=%0d data=%h mask=%h", a, d, s);
    endtask

    task automatic do_read(input int a);
        R_EN = 1'b1; R_ADDR = ADDR_W'(a);
        tick();
        R_EN = 1'b0;
        $display("read addr=%0d real=%h raw=%h sgl=%b dbl=%b", R_ADDRr, real_data, wrong_real_data, SGLl, DBLl);
    endtask

    // SECDED contract: 0 flipped data bits -> clean, 1 -> corrected, 2 -> detected only.
    function automatic void model(input int a);
        int n;
        n  = $countones(ms[a]);
        ew = md[a] ^ ms[a];
        es = (n == 1);
        ed = (n == 2);
        er = (n == 1) ? md[a] : ew;
    endfunction

    function automatic logic [143:0] pack_exp(input int a);
        model(a);
        return {ADDR_W'(a), er, ew, es, ed};
    endfunction

    always_comb got = {R_ADDRr, real_data, wrong_real_data, SGLl, DBLl};

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (got !== 144'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want %h", got, 144'd0);
        end
    endtask

    task automatic test_basic();
        do_write(1, 64'd10, 64'd0);
        do_write(2, 64'd20, 64'd2);
        do_write(3, 64'd30, 64'd3);
        do_read(1);
        want = {14'd1, 64'd10, 64'd10, 1'b0, 1'b0};
        checks++;
        if (got !== want) begin errors++; $display("FAIL clean_read got %h want %h", got, want); end
        do_read(2);
        want = {14'd2, 64'd20, 64'd22, 1'b1, 1'b0};
        checks++;
        if (got !== want) begin errors++; $display("FAIL single_err got %h want %h", got, want); end
        do_read(3);
        want = {14'd3, 64'd29, 64'd29, 1'b0, 1'b1};
        checks++;
        if (got !== want) begin errors++; $display("FAIL double_err got %h want %h", got, want); end
    endtask

    task automatic test_hold();
        want = {14'd3, 64'd29, 64'd29, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            R_EN = 1'b0;
            R_ADDR = ADDR_W'($urandom);
            tick();
            checks++;
            if (got !== want) begin errors++; $display("FAIL hold_%0d got %h want %h", i, got, want); end
        end
    endtask

    task automatic test_no_write();
        do_write(5, 64'd40, 64'd66);
        do_read(5);
        want = {14'd5, 64'd106, 64'd106, 1'b0, 1'b1};
        checks++;
        if (got !== want) begin errors++; $display("FAIL double_far got %h want %h", got, want); end
        W_EN = 1'b0; W_ADDR = 14'd5; INn = {$urandom, $urandom}; selectt = 64'd0;
        tick();
        W_ADDR = 14'd3; INn = {$urandom, $urandom};
        tick();
        do_read(5);
        checks++;
        if (got !== want) begin errors++; $display("FAIL wen0_addr5 got %h want %h", got, want); end
        do_read(3);
        want = {14'd3, 64'd29, 64'd29, 1'b0, 1'b1};
        checks++;
        if (got !== want) begin errors++; $display("FAIL wen0_addr3 got %h want %h", got, want); end
    endtask

    task automatic test_read_first();
        W_EN = 1'b1; W_ADDR = 14'd1; INn = 64'd55; selectt = 64'd0;
        R_EN = 1'b1; R_ADDR = 14'd1;
        tick();
        W_EN = 1'b0; R_EN = 1'b0;
        $display("write+read addr=1 data=%h returned real=%h", 64'd55, real_data);
        want = {14'd1, 64'd10, 64'd10, 1'b0, 1'b0};
        checks++;
        if (got !== want) begin errors++; $display("FAIL read_first_old got %h want %h", got, want); end
        md[1] = 64'd55;
        do_read(1);
        want = {14'd1, 64'd55, 64'd55, 1'b0, 1'b0};
        checks++;
        if (got !== want) begin errors++; $display("FAIL read_first_new got %h want %h", got, want); end
    endtask

    task automatic test_back_to_back();
        int b1, b2, k;
        logic [63:0] s;
        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 2);
            b1 = $urandom_range(0, 63);
            b2 = (b1 + $urandom_range(1, 63)) % 64;
            s  = 64'd0;
            if (k >= 1) s[b1] = 1'b1;
            if (k == 2) s[b2] = 1'b1;
            do_write(1000 + i, {$urandom, $urandom}, s);
        end
        R_EN = 1'b1;
        for (int i = 0; i < 40; i++) begin
            R_ADDR = ADDR_W'(1000 + i);
            tick();
            $display("read addr=%0d real=%h raw=%h sgl=%b dbl=%b", R_ADDRr, real_data, wrong_real_data, SGLl, DBLl);
            want = pack_exp(1000 + i);
            checks++;
            if (got !== want) begin errors++; $display("FAIL rand_read_%0d got %h want %h", i, got, want); end
        end
        R_EN = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_read(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (got !== 144'd0) begin errors++; $display("FAIL mid_reset got %h want %h", got, 144'd0); end
        reset = 1'b1;
        do_write(9, 64'd77, 64'd0);
        reset = 1'b0;
`ifdef ECC_ERR_CNT_EN
        checks++;
        if ({sgl_cnt, dbl_cnt} !== 32'd0) begin
            errors++; $display("FAIL cnt_reset got %h want %h", {sgl_cnt, dbl_cnt}, 32'd0);
        end
`endif
        do_read(2);
        want = {14'd2, 64'd20, 64'd22, 1'b1, 1'b0};
        checks++;
        if (got !== want) begin errors++; $display("FAIL retained_addr2 got %h want %h", got, want); end
        do_read(3);
        tick();
`ifdef ECC_ERR_CNT_EN
        checks++;
        if ({sgl_cnt, dbl_cnt} !== {16'd1, 16'd1}) begin
            errors++; $display("FAIL cnt_after got %h want %h", {sgl_cnt, dbl_cnt}, {16'd1, 16'd1});
        end
`endif
        do_read(9);
        want = {14'd9, 64'd77, 64'd77, 1'b0, 1'b0};
        checks++;
        if (got !== want) begin errors++; $display("FAIL write_during_reset got %h want %h", got, want); end
    endtask

    initial begin
        reset = 1'b1; W_EN = 1'b0; R_EN = 1'b0;
        W_ADDR = '0; R_ADDR = '0; INn = '0; selectt = '0;
        test_reset();
        test_basic();
        test_hold();
        test_no_write();
        test_read_first();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/test7_v2_ecc.md
Name: test7_v2_ecc

Overview:
- 64-bit single-port-write / single-port-read RAM protected by SECDED (72,64) Hamming ECC, with a built-in error-injection mask.
- Sits in the ECC demo/characterisation path of the design.
- Returns both the corrected read word and the raw stored word.
- Flags single-bit (corrected) and double-bit (detected) errors.

Parameters:
- ADDR_W, 14, address width for read and write ports.
- DEPTH, 16384, number of 72-bit words stored; must be at most 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous active-high reset.
- INn  in  64  write data.
- selectt  in  64  error-injection mask, XORed into data bits at write time.
- W_EN  in  1  write enable.
- W_ADDR  in  ADDR_W  write address.
- R_EN  in  1  read enable.
- R_ADDR  in  ADDR_W  read address.
- R_ADDRr  out  ADDR_W  registered address of the word currently presented.
- real_data  out  64  ECC-corrected read data.
- wrong_real_data  out  64  raw stored data bits, uncorrected.
- SGLl  out  1  single-bit error detected and corrected.
- DBLl  out  1  uncorrectable (double) error detected.

Behaviour:
- Clock and reset:
  - Single clock; reset is synchronous and active-high.
  - Reset clears R_ADDRr, real_data, wrong_real_data, SGLl and DBLl to 0.
  - Memory contents are not cleared by reset.
- Encoding:
  - Hamming codeword positions 1..71; check bits sit at positions 1, 2, 4, 8, 16, 32, 64.
  - INn[0..63] fill the remaining positions in ascending order.
  - P[i] is the XOR of all data positions whose index has bit i set.
  - Bit 72 is overall parity: XOR of positions 1..71.
- Write:
  - When W_EN=1 at a rising edge, compute the 8 check bits from the clean INn.
  - Store {check, INn ^ selectt} at W_ADDR. The injected error affects data bits only.
  - W_ADDR >= DEPTH: write is ignored.
- Read latency: 1 cycle.
  - When R_EN=1 at edge N, the memory word at R_ADDR is registered, and R_ADDRr <= R_ADDR.
  - Outputs are valid after edge N. Decode is combinational from the registered word.
  - R_EN=0: registered word and R_ADDRr hold, so outputs hold.
- Decode (S = 7-bit syndrome, Q = overall parity mismatch):
  - S=0, Q=0: no error; SGLl=0, DBLl=0; real_data = raw.
  - S!=0, Q=1, S<=71: single error. Flip position S; if S is a check position, data is unchanged. SGLl=1, DBLl=0.
  - S=0, Q=1: error in the overall parity bit; SGLl=1; data unchanged.
  - S!=0, Q=0, or S>71 with Q=1: DBLl=1, SGLl=0; real_data = raw, uncorrected.
- wrong_real_data always equals the stored data bits.
- Same-cycle read and write to the same address: read-first, i.e. the old contents are returned.
- Reading a never-written address returns undefined contents. Flags reflect whatever is stored.
- Reset asserted in the same cycle as W_EN: the write still occurs. Reset has priority over the read registers.

Optional Feature:
- Macro: ECC_ERR_CNT_EN.
- When defined:
  - Adds outputs sgl_cnt[15:0] and dbl_cnt[15:0].
  - Each is a saturating counter, incremented on every cycle after a read edge (R_EN=1) whose decode gives SGLl or DBLl respectively.
  - Both counters are cleared by reset.
- When undefined:
  - Counters and ports are absent.
  - Core behaviour is identical.

Test Plan:
1. Write addr1 INn=10 selectt=0, then read addr1 -> real_data=10, wrong_real_data=10, SGLl=0, DBLl=0, R_ADDRr=1.
2. Write addr2 INn=20 selectt=2, then read addr2 -> wrong_real_data=22, real_data=20, SGLl=1, DBLl=0.
3. Write addr3 INn=30 selectt=3, then read addr3 -> wrong_real_data=29, DBLl=1, SGLl=0, real_data=29.
4. Write addr5 INn=40 selectt=66 -> wrong_real_data=106, DBLl=1. Also set W_EN=0 and change W_ADDR/INn -> stored words are unchanged on re-read.
5. R_EN=0 while R_ADDR changes -> all outputs and R_ADDRr hold. Same-cycle write and read of addr1 with new data -> old value returned, new value on the next read.
6. Reset mid-stream -> all outputs 0 on the next edge; memory is retained, and re-reading addr2 gives real_data=20, SGLl=1. With ECC_ERR_CNT_EN defined, counters reset to 0 and count 1 single error and 1 double error after the addr2 and addr3 reads.
